tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_pkg.sv | 29 ++
 rtl/slot_counter.sv | 63 ++++++
 rtl/tdm_demux.sv | 179 +++++++++++++++++
 tb/tb_tdm_demux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the TDM demultiplexer slice:
//   - state_e        : framing FSM states (HUNT searches for sync, LOCKED
//                      follows the slot sequence of an acquired frame)
//   - DEFAULT_CHANNELS : default number of time slots per frame
//   - slot_width()   : width of a slot index for a given channel count
// -----------------------------------------------------------------------------
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int DEFAULT_CHANNELS = 4;
  localparam int MIN_CHANNELS     = 2;
  localparam int MAX_CHANNELS     = 16;

  // Width of a slot index. Never returns zero so that a counter can always be
  // declared, even for degenerate parameter values.
  function automatic int slot_width(input int ch);
    if (ch < MIN_CHANNELS) begin
      return 1;
    end
    return $clog2(ch);
  endfunction

endpackage

// File: rtl/slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Modulo-CHANNELS slot index counter for the TDM demultiplexer.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   reset  in   synchronous active-high reset, count returns to 0
//   inc    in   advance the count by one (wraps CHANNELS-1 -> 0)
//   clear  in   restart the count from 0
//   count  out  current slot index (W bits)
//   tc     out  terminal count flag, high while count == CHANNELS-1
//
// clear and inc together restart the count and step past slot 0 in the same
// edge, landing on 1. The demux uses this when a sync bit is captured: the
// sync cycle itself is slot 0, so the next expected slot is 1.
// -----------------------------------------------------------------------------
module slot_counter
  import tdm_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int W        = slot_width(CHANNELS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(CHANNELS - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last;

  assign at_last = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear && inc) begin
      count_d = ONE;
    end else if (clear) begin
      count_d = '0;
    end else if (inc) begin
      // Explicit wrap keeps non-power-of-two channel counts correct.
      count_d = at_last ? '0 : (count_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = at_last;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Serial time-division demultiplexer. A frame is CHANNELS consecutive
// qualified bits on din, the first one flagged by sync. Bits are gathered in
// a shadow register and presented in parallel on dout once the whole frame
// has arrived.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset (wins over enable/sync)
//   din        in   serial data bit for the current slot
//   sync       in   marks slot 0 of a frame
//   enable     in   qualifies din and sync; cycles with enable=0 are ignored
//   dout       out  [CHANNELS-1:0] last complete frame, bit k = slot k
//   out_valid  out  one-cycle pulse when dout is updated
//   locked     out  high while the framing FSM is LOCKED
//   err        out  one-cycle pulse on a framing error (misplaced or
//                   missing sync)
//
// Every output comes straight from a flop; din only reaches dout through the
// shadow/dout registers.
// -----------------------------------------------------------------------------
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic                sync,
  input  logic                enable,
  output logic [CHANNELS-1:0] dout,
  output logic                out_valid,
  output logic                locked,
  output logic                err
);

  localparam int SLOT_W = slot_width(CHANNELS);

  // ---------------------------------------------------------------------------
  // Slot counter: index of the slot the next qualified cycle belongs to.
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_q;
  logic              slot_tc;
  logic              cnt_inc;
  logic              cnt_clear;

  slot_counter #(
    .CHANNELS (CHANNELS),
    .W        (SLOT_W)
  ) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clear (cnt_clear),
    .count (slot_q),
    .tc    (slot_tc)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;

  // The final slot is never stored: it goes directly into dout together with
  // the shadow bits, so only CHANNELS-1 shadow bits are needed.
  logic [CHANNELS-2:0] shadow_q;
  logic [CHANNELS-2:0] shadow_d;

  logic [CHANNELS-1:0] dout_q;
  logic [CHANNELS-1:0] dout_d;
  logic                out_valid_q;
  logic                out_valid_d;
  logic                err_q;
  logic                err_d;

  // Shadow write strobes produced by the FSM.
  logic load_first;    // store din into shadow[0] (sync captured)
  logic capture_slot;  // store din into shadow[slot_q] (mid-frame slot)

  logic at_slot0;
  assign at_slot0 = (slot_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clear    = 1'b0;
    load_first   = 1'b0;
    capture_slot = 1'b0;

    if (enable) begin
      unique case (state_q)
        HUNT: begin
          // Bits without sync are discarded until a frame start is seen.
          if (sync) begin
            load_first = 1'b1;
            cnt_clear  = 1'b1;
            cnt_inc    = 1'b1;
            state_d    = LOCKED;
          end
        end

        LOCKED: begin
          if (sync) begin
            // Sync always restarts the frame. Outside slot 0 it is a
            // misplaced sync: the partial frame is dropped, and this also
            // covers sync on the last slot, where the error beats completion.
            load_first = 1'b1;
            cnt_clear  = 1'b1;
            cnt_inc    = 1'b1;
            err_d      = !at_slot0;
          end else if (at_slot0) begin
            // Expected a frame start but none came: lose lock.
            err_d     = 1'b1;
            state_d   = HUNT;
          end else if (slot_tc) begin
            // Last slot: publish the frame, counter wraps to 0.
            dout_d      = {din, shadow_q};
            out_valid_d = 1'b1;
            cnt_inc     = 1'b1;
          end else begin
            capture_slot = 1'b1;
            cnt_inc      = 1'b1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow register write decode, one bit per slot 0..CHANNELS-2.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS - 1; gi++) begin : g_shadow
      logic hit;
      assign hit = (load_first && (gi == 0)) ||
                   (capture_slot && (slot_q == SLOT_W'(gi)));
      assign shadow_d[gi] = hit ? din : shadow_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
// Directed bench for tdm_demux with CHANNELS=4. Each step drives one cycle of
// (enable, sync, din), waits for the rising edge and samples 1 ns later.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

  localparam int CH = 4;

  logic          clk;
  logic          reset;
  logic          din;
  logic          sync;
  logic          enable;
  logic [CH-1:0] dout;
  logic          out_valid;
  logic          locked;
  logic          err;

  int checks;
  int errors;

  tdm_demux #(.CHANNELS(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .sync      (sync),
    .enable    (enable),
    .dout      (dout),
    .out_valid (out_valid),
    .locked    (locked),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic en, input logic sy, input logic d);
    enable = en;
    sync   = sy;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    checks++;
    if (dout !== 4'b0000 || out_valid !== 1'b0 || err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%b ov=%b err=%b locked=%b, want 0000 0 0 0",
               dout, out_valid, err, locked);
    end
    $display("reset: dout=%b ov=%b err=%b locked=%b", dout, out_valid, err, locked);
    // Bits without sync in HUNT are discarded.
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL hunt_no_sync: locked=%b err=%b, want 0 0", locked, err);
    end
  endtask

  task automatic test_normal_frame();
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (locked !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_lock: locked=%b ov=%b, want 1 0", locked, out_valid);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (dout !== 4'b1101 || out_valid !== 1'b1 || locked !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL normal_frame: dout=%b ov=%b locked=%b err=%b, want 1101 1 1 0",
               dout, out_valid, locked, err);
    end
    $display("normal: dout=%b ov=%b", dout, out_valid);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || dout !== 4'b1101) begin
      errors++;
      $display("FAIL normal_pulse: ov=%b dout=%b, want 0 1101", out_valid, dout);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);  // ignored, sync included
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (err !== 1'b0 || out_valid !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: err=%b ov=%b locked=%b, want 0 0 1", err, out_valid, locked);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (dout !== 4'b1101 || out_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL stall_frame: dout=%b ov=%b err=%b, want 1101 1 0", dout, out_valid, err);
    end
    $display("stall: dout=%b ov=%b", dout, out_valid);
  endtask

  task automatic test_misplaced_sync();
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);  // sync at slot 2
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || dout !== 4'b0000 || locked !== 1'b1) begin
      errors++;
      $display("FAIL misplaced_err: err=%b ov=%b dout=%b locked=%b, want 1 0 0000 1",
               err, out_valid, dout, locked);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL misplaced_pulse: err=%b, want 0", err);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (dout !== 4'b0110 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL misplaced_frame: dout=%b ov=%b, want 0110 1", dout, out_valid);
    end
    $display("misplaced: dout=%b ov=%b", dout, out_valid);
  endtask

  task automatic test_sync_last_slot();
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);  // sync on slot 3: error wins over completion
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0 || dout !== 4'b0000) begin
      errors++;
      $display("FAIL last_slot_sync: err=%b ov=%b dout=%b, want 1 0 0000", err, out_valid, dout);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (dout !== 4'b1001 || out_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL last_slot_frame: dout=%b ov=%b err=%b, want 1001 1 0", dout, out_valid, err);
    end
    $display("last_slot: dout=%b ov=%b", dout, out_valid);
  endtask

  task automatic test_missing_sync();
    int ov_seen;
    int err_seen;
    int unlocked_bad;
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);  // slot 0 without sync
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL missing_sync: err=%b locked=%b ov=%b, want 1 0 0", err, locked, out_valid);
    end
    ov_seen = 0;
    err_seen = 0;
    unlocked_bad = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (out_valid !== 1'b0) ov_seen++;
      if (err !== 1'b0) err_seen++;
      if (locked !== 1'b0) unlocked_bad++;
    end
    checks++;
    if (ov_seen != 0 || err_seen != 0 || unlocked_bad != 0 || dout !== 4'b1101) begin
      errors++;
      $display("FAIL missing_hunt: ov=%0d err=%0d locked=%0d dout=%b, want 0 0 0 1101",
               ov_seen, err_seen, unlocked_bad, dout);
    end
    $display("missing: locked=%b dout=%b", locked, dout);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    do_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);  // dout=1101
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);  // now at slot 2
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1);  // reset beats enable/sync
    reset = 1'b0;
    checks++;
    if (locked !== 1'b0 || dout !== 4'b0000 || out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: locked=%b dout=%b ov=%b err=%b, want 0 0000 0 0",
               locked, dout, out_valid, err);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (out_valid !== 1'b0 || err !== 1'b0 || locked !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_after: bad_cycles=%0d, want 0", bad);
    end
    $display("reset_mid: locked=%b dout=%b", locked, dout);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (dout !== 4'b1010 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: dout=%b ov=%b, want 1010 1", dout, out_valid);
    end
    $display("b2b first: dout=%b ov=%b", dout, out_valid);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL b2b_resync: ov=%b err=%b locked=%b, want 0 0 1", out_valid, err, locked);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (dout !== 4'b0101 || out_valid !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: dout=%b ov=%b err=%b, want 0101 1 0", dout, out_valid, err);
    end
    $display("b2b second: dout=%b ov=%b", dout, out_valid);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    enable = 1'b0;
    sync   = 1'b0;
    din    = 1'b0;
    test_reset();
    test_normal_frame();
    test_stall();
    test_misplaced_sync();
    test_sync_last_slot();
    test_missing_sync();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
